// File: rtl/calculator_pkg.sv
// calculator_pkg: shared parameters, controller state encoding and the
// 64-bit add helper for the memory-to-memory adder (calculator_top).
package calculator_pkg;

  localparam int ADDR_W    = 10;    // SRAM address width
  localparam int DATA_W    = 32;    // width of one SRAM word (half of a 64-bit operand)
  localparam int MEM_DEPTH = 1024;  // words per SRAM

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ1 = 3'd1,
    S_READ2 = 3'd2,
    S_ADD   = 3'd3,
    S_WRITE = 3'd4,
    S_END   = 3'd5
  } state_t;

  // Modulo-2^64 sum; the carry out of bit 63 is dropped by the result width.
  function automatic logic [2*DATA_W-1:0] add64(input logic [2*DATA_W-1:0] a,
                                                input logic [2*DATA_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/calculator_controller.sv
// controller: FSM that walks the read range two words at a time, adds each
// pair as 64-bit values and writes one sum per pair into the write range,
// then parks in S_END. Also counts busy cycles in cycle_count.
// Ports: clk; rst_n (async, active-low); range inputs (sampled in S_IDLE);
//        rd_data ({hi, lo} from the SRAMs); rd_en/rd_addr (read request);
//        wr_en/w_addr/wr_data (write request, low half -> A, high half -> B).
// All SRAM control outputs are registered, so each request is set up on the
// edge that enters the state in which the SRAMs act on it.
module controller
  import calculator_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   read_start_addr,
  input  logic [ADDR_W-1:0]   read_end_addr,
  input  logic [ADDR_W-1:0]   write_start_addr,
  input  logic [ADDR_W-1:0]   write_end_addr,
  input  logic [2*DATA_W-1:0] rd_data,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   w_addr,
  output logic [2*DATA_W-1:0] wr_data
);

  state_t              state, state_d;
  logic [31:0]         cycle_count, cycle_count_d;
  logic [ADDR_W-1:0]   r_q, r_d, w_q, w_d;
  logic [ADDR_W-1:0]   read_end_q, read_end_d, write_end_q, write_end_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [2*DATA_W-1:0] op1_q, op1_d, sum_q, sum_d;
  logic                no_op2_s, last_pair_s;

  // r is the last address of the range: the pair has no second operand.
  assign no_op2_s    = (r_q == read_end_q);
  // Widened by one bit so r+1 cannot wrap at the top of the address space.
  assign last_pair_s = (({1'b0, r_q} + (ADDR_W+1)'(1)) >= {1'b0, read_end_q});

  // Next-state, pointer, operand and SRAM-request logic.
  always_comb begin
    state_d       = state;
    r_d           = r_q;
    w_d           = w_q;
    read_end_d    = read_end_q;
    write_end_d   = write_end_q;
    rd_addr_d     = rd_addr_q;
    rd_en_d       = 1'b0;
    wr_en_d       = 1'b0;
    op1_d         = op1_q;
    sum_d         = sum_q;
    if ((state != S_IDLE) && (state != S_END)) begin
      cycle_count_d = cycle_count + 32'd1;
    end else begin
      cycle_count_d = cycle_count;
    end

    case (state)
      S_IDLE: begin
        read_end_d  = read_end_addr;
        write_end_d = write_end_addr;
        r_d         = read_start_addr;
        w_d         = write_start_addr;
        if ((read_start_addr > read_end_addr) || (write_start_addr > write_end_addr)) begin
          state_d = S_END;
        end else begin
          state_d   = S_READ1;
          rd_en_d   = 1'b1;
          rd_addr_d = read_start_addr;
        end
      end
      S_READ1: begin
        state_d = S_READ2;
        if (!no_op2_s) begin
          rd_en_d   = 1'b1;
          rd_addr_d = r_q + ADDR_W'(1);
        end else begin
          rd_en_d   = 1'b0;
        end
      end
      S_READ2: begin
        state_d = S_ADD;
        op1_d   = rd_data;
      end
      S_ADD: begin
        state_d = S_WRITE;
        wr_en_d = 1'b1;
        if (no_op2_s) begin
          sum_d = add64(op1_q, {(2*DATA_W){1'b0}});
        end else begin
          sum_d = add64(op1_q, rd_data);
        end
      end
      S_WRITE: begin
        if ((w_q == write_end_q) || last_pair_s) begin
          state_d = S_END;
        end else begin
          state_d   = S_READ1;
          r_d       = r_q + ADDR_W'(2);
          w_d       = w_q + ADDR_W'(1);
          rd_en_d   = 1'b1;
          rd_addr_d = r_q + ADDR_W'(2);
        end
      end
      S_END: begin
        state_d = S_END;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state register; reset never touches the SRAM contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cycle_count <= 32'd0;
      r_q         <= {ADDR_W{1'b0}};
      w_q         <= {ADDR_W{1'b0}};
      read_end_q  <= {ADDR_W{1'b0}};
      write_end_q <= {ADDR_W{1'b0}};
      rd_addr_q   <= {ADDR_W{1'b0}};
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      op1_q       <= {(2*DATA_W){1'b0}};
      sum_q       <= {(2*DATA_W){1'b0}};
    end else begin
      state       <= state_d;
      cycle_count <= cycle_count_d;
      r_q         <= r_d;
      w_q         <= w_d;
      read_end_q  <= read_end_d;
      write_end_q <= write_end_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      op1_q       <= op1_d;
      sum_q       <= sum_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign w_addr  = w_q;
  assign wr_data = sum_q;

endmodule

// File: rtl/calculator_sram.sv
// sram: single-port MEM_DEPTH x DATA_W memory, synchronous write and
// synchronous read with one cycle of latency. No reset: contents survive
// controller reset and may be preloaded from outside.
// Ports: clk; en (access this cycle); we (write when en); addr; wdata;
//        rdata (word read on the previous enabled, non-write cycle).
module sram
  import calculator_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] memory [0:MEM_DEPTH-1];
  logic [DATA_W-1:0] rdata_q;

  // Single port: either write the addressed word or register it for reading.
  always_ff @(posedge clk) begin
    if (en && we) begin
      memory[addr] <= wdata;
    end else if (en) begin
      rdata_q <= memory[addr];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/calculator_top.sv
// calculator_top: memory-to-memory 64-bit adder. sram_A holds the low
// halves, sram_B the high halves of 64-bit words; u_ctrl sums consecutive
// operand pairs from the read range into the write range.
// Ports: clk; rst (async, active-low, controller only); read_start_addr,
//        read_end_addr, write_start_addr, write_end_addr (inclusive ranges).
// No outputs: results live in the SRAMs.
module calculator_top
  import calculator_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_start_addr,
  input  logic [ADDR_W-1:0] read_end_addr,
  input  logic [ADDR_W-1:0] write_start_addr,
  input  logic [ADDR_W-1:0] write_end_addr
);

  logic                rd_en, wr_en;
  logic [ADDR_W-1:0]   rd_addr, w_addr, sram_addr;
  logic [2*DATA_W-1:0] rd_data, wr_data;
  logic [DATA_W-1:0]   rdata_a, rdata_b;

  // Both SRAMs share one address: the write address wins when writing.
  assign sram_addr = wr_en ? w_addr : rd_addr;
  assign rd_data   = {rdata_b, rdata_a};

  controller u_ctrl (
    .clk              (clk),
    .rst_n            (rst),
    .read_start_addr  (read_start_addr),
    .read_end_addr    (read_end_addr),
    .write_start_addr (write_start_addr),
    .write_end_addr   (write_end_addr),
    .rd_data          (rd_data),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .wr_en            (wr_en),
    .w_addr           (w_addr),
    .wr_data          (wr_data)
  );

  sram sram_A (
    .clk   (clk),
    .en    (rd_en | wr_en),
    .we    (wr_en),
    .addr  (sram_addr),
    .wdata (wr_data[DATA_W-1:0]),
    .rdata (rdata_a)
  );

  sram sram_B (
    .clk   (clk),
    .en    (rd_en | wr_en),
    .we    (wr_en),
    .addr  (sram_addr),
    .wdata (wr_data[2*DATA_W-1:DATA_W]),
    .rdata (rdata_b)
  );

endmodule

// File: tb/tb_calculator_top.sv
// Testbench for calculator_top: random memory preload, a reference model of
// the pairwise 64-bit sums, a write scoreboard fed by the model and emptied
// by a monitor watching the write state, plus final memory-image checks.
module tb_calculator_top;
  import calculator_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] rsa = 10'd0, rea = 10'd0, wsa = 10'd0, wea = 10'd0;

  calculator_top dut (
    .clk              (clk),
    .rst              (rst),
    .read_start_addr  (rsa),
    .read_end_addr    (rea),
    .write_start_addr (wsa),
    .write_end_addr   (wea)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_lo [0:1023];
  logic [31:0] m_hi [0:1023];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_pend = 1'b0;
  int          mon_addr = 0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: a cycle seen in S_WRITE means the SRAMs were written on the
  // following edge; compare that write with the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        mon_pend = 1'b0;
      end else begin
        if (mon_pend) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_write: write at address %0d, none expected", mon_addr);
          end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 64'(mon_addr), 64'(mon_e.addr));
            check("wr_data", {dut.sram_B.memory[mon_addr], dut.sram_A.memory[mon_addr]}, mon_e.data);
            m_lo[mon_e.addr] = mon_e.data[31:0];
            m_hi[mon_e.addr] = mon_e.data[63:32];
          end
        end
        mon_pend = (dut.u_ctrl.state == S_WRITE);
        mon_addr = int'(dut.w_addr);
      end
    end
  end

  // Reference model: pair (r, r+1) -> w, second operand 0 past the range end,
  // stop when either range is exhausted. Returns the number of results.
  function automatic int build_expect(input int rs, input int re, input int ws, input int we);
    int   r = rs;
    int   w = ws;
    int   n = 0;
    exp_t e;
    logic [63:0] a, b;
    exp_q.delete();
    while (r <= re && w <= we) begin
      a = {m_hi[r], m_lo[r]};
      b = (r + 1 <= re) ? {m_hi[r+1], m_lo[r+1]} : 64'd0;
      e.addr = w;
      e.data = a + b;
      exp_q.push_back(e);
      r += 2;
      w += 1;
      n += 1;
    end
    return n;
  endfunction

  task automatic preload(input int mode);
    for (int i = 0; i < 1024; i++) begin
      m_lo[i] = $urandom;
      m_hi[i] = $urandom;
    end
    if (mode == 1) begin
      m_lo[0] = 32'hFFFF_FFFF; m_hi[0] = 32'h0000_0000;
      m_lo[1] = 32'h0000_0001; m_hi[1] = 32'h0000_0000;
      m_lo[2] = 32'hFFFF_FFFF; m_hi[2] = 32'hFFFF_FFFF;
      m_lo[3] = 32'hFFFF_FFFF; m_hi[3] = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < 1024; i++) begin
      dut.sram_A.memory[i] = m_lo[i];
      dut.sram_B.memory[i] = m_hi[i];
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 64'(dut.u_ctrl.state), 64'(S_IDLE));
    check({tag, "_cycles"}, 64'(dut.u_ctrl.cycle_count), 64'd0);
    check({tag, "_w_addr"}, 64'(dut.w_addr), 64'd0);
  endtask

  task automatic run_case(input int rs, input int re, input int ws, input int we,
                          input int mode, input int abort_at);
    int n;
    int bad;
    @(negedge clk);
    #2 rst = 1'b0;
    rsa = 10'(rs); rea = 10'(re); wsa = 10'(ws); wea = 10'(we);
    preload(mode);
    repeat (2) @(negedge clk);
    #1 check_idle("reset");
    n = build_expect(rs, re, ws, we);
    #1 rst = 1'b1;
    if (abort_at > 0) begin
      repeat (abort_at) @(negedge clk);
      #2 rst = 1'b0;
      exp_q.delete();
      #1 check_idle("abort");
      repeat (2) @(negedge clk);
      n = build_expect(rs, re, ws, we);
      #2 rst = 1'b1;
    end
    for (int i = 0; i < 6000; i++) begin
      if (dut.u_ctrl.state == S_END) break;
      @(negedge clk);
    end
    check("reach_end", 64'(dut.u_ctrl.state), 64'(S_END));
    @(negedge clk);
    #1;
    check("writes_left", 64'(exp_q.size()), 64'd0);
    check("cycle_count", 64'(dut.u_ctrl.cycle_count), 64'(4 * n));
    bad = 0;
    for (int a = 0; a < 1024; a++) begin
      if ({dut.sram_B.memory[a], dut.sram_A.memory[a]} !== {m_hi[a], m_lo[a]}) bad++;
    end
    check("mem_image_bad_words", 64'(bad), 64'd0);
  endtask

  initial begin
    int rs, re, ws, we;
    // Reference case with carry-across-halves and 64-bit overflow pairs.
    run_case(0, 511, 768, 1023, 1, 0);
    check("cycles_ref", 64'(dut.u_ctrl.cycle_count), 64'd1024);
    check("carry_768", {dut.sram_B.memory[768], dut.sram_A.memory[768]}, 64'h0000_0001_0000_0000);
    check("ovf_769", {dut.sram_B.memory[769], dut.sram_A.memory[769]}, 64'hFFFF_FFFF_FFFF_FFFE);
    // Short write range: four results only.
    run_case(0, 511, 1020, 1023, 0, 0);
    check("cycles_short", 64'(dut.u_ctrl.cycle_count), 64'd16);
    // Odd read range: last operand paired with zero.
    run_case(0, 2, 900, 1023, 0, 0);
    check("odd_901", {dut.sram_B.memory[901], dut.sram_A.memory[901]},
          {m_hi[2], m_lo[2]});
    // Empty read range goes straight to S_END.
    run_case(10, 5, 600, 700, 0, 0);
    // Reset in the middle of a run, then a full rerun.
    run_case(0, 511, 768, 1023, 1, 50);
    // Randomised non-overlapping ranges.
    for (int k = 0; k < 3; k++) begin
      rs = $urandom_range(0, 400);
      re = rs + $urandom_range(0, 99);
      ws = $urandom_range(512, 900);
      we = ws + $urandom_range(0, 123);
      run_case(rs, re, ws, we, 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
